sram_dp: RTL

SRAM_DP -- requirements
Module: sram_dp

---
 rtl/sram_dp.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_dp.sv
// sram_dp: single-clock dual-port SRAM (one write + one read port per cycle)
// with optional zero-fill after reset and out-of-range address reporting.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cs                   chip select, gates both ports
//   wr_en/wr_addr/wr_data  write port
//   rd_req/rd_addr       read port request
//   rd_data, rd_valid    registered read data and its one-cycle valid pulse
//   addr_err             one-cycle pulse, an accepted access was out of range
//   init_done            high while the block accepts accesses
module sram_dp #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic              init_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              addr_err_q, addr_err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;

    logic              wr_in;
    logic              rd_in;
    logic              wr_acc;
    logic              rd_acc;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_in  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in  = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_idx = wr_addr[IDX_W-1:0];
    assign rd_idx = rd_addr[IDX_W-1:0];
    assign wr_acc = (state_q == READY) & cs & wr_en;
    assign rd_acc = (state_q == READY) & cs & rd_req;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = clr_cnt_q;
        mem_wdata  = '0;
        unique case (state_q)
            CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d   = READY;
                        clr_cnt_d = '0;
                    end
                end else begin
                    state_d = READY;
                end
            end
            READY: begin
                if (wr_acc && wr_in) begin
                    mem_we    = 1'b1;
                    mem_idx   = wr_idx;
                    mem_wdata = wr_data;
                end
                addr_err_d = (wr_acc & ~wr_in) | (rd_acc & ~rd_in);
                if (rd_acc) begin
                    rd_valid_d = 1'b1;
                    if (!rd_in) begin
                        rd_data_d = '0;
                    end else if (wr_acc && wr_in && (wr_idx == rd_idx)) begin
                        // write-first bypass for a same-address collision
                        rd_data_d = wr_data;
                    end else begin
                        rd_data_d = mem[rd_idx];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Array has no reset; it is zeroed by the CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign init_done = (state_q == READY);

endmodule
